// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone requester arbiter: FSM state encoding and
// the default requester count.
package wb_arb_pkg;

    localparam int NUM_REQ_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END,
        S_DONE
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first eligible port at or after
// last_grant+1, wrapping modulo NUM_REQ.
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      last_grant,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx
);

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (eligible[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/wb_requester_arbiter.sv
// Arbitrates NUM_REQ requester ports onto one bus manager, one transaction
// at a time, round-robin among ports asserting exactly one of read/write.
module wb_requester_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_REQ-1:0]      REQ_READ_I,
    input  logic [NUM_REQ-1:0]      REQ_WRITE_I,
    input  logic [NUM_REQ*32-1:0]   REQ_ADR_I,
    input  logic [NUM_REQ*32-1:0]   REQ_DAT_I,
    input  logic [NUM_REQ*4-1:0]    REQ_SEL_I,
    output logic [NUM_REQ*32-1:0]   REQ_DAT_O,
    output logic [NUM_REQ-1:0]      REQ_BUSY_O,
    output logic [NUM_REQ-1:0]      REQ_DONE_O,
    output logic                    MGR_READ_O,
    output logic                    MGR_WRITE_O,
    output logic [31:0]             MGR_ADR_O,
    output logic [31:0]             MGR_DAT_O,
    output logic [3:0]              MGR_SEL_O,
    input  logic                    MGR_BUSY_I,
    input  logic [31:0]             MGR_DAT_I
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e                 state_q, state_d;
    logic [IW-1:0]              last_q, last_d;
    logic [IW-1:0]              win_q, win_d;
    logic                       rd_q, rd_d;
    logic [31:0]                adr_q, adr_d;
    logic [31:0]                wdat_q, wdat_d;
    logic [3:0]                 sel_q, sel_d;
    logic [NUM_REQ-1:0][31:0]   rdat_q, rdat_d;
    logic                       mgr_rd_q, mgr_rd_d;
    logic                       mgr_wr_q, mgr_wr_d;

    logic [NUM_REQ-1:0]         eligible;
    logic                       grant_valid;
    logic [IW-1:0]              grant_idx;
    logic                       active;

    // A port raising both read and write is treated as not requesting.
    assign eligible = REQ_READ_I ^ REQ_WRITE_I;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .eligible    (eligible),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        rd_d     = rd_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        rdat_d   = rdat_q;
        mgr_rd_d = 1'b0;
        mgr_wr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    win_d    = grant_idx;
                    rd_d     = REQ_READ_I[grant_idx];
                    adr_d    = REQ_ADR_I[32*int'(grant_idx) +: 32];
                    wdat_d   = REQ_READ_I[grant_idx] ? 32'h0
                                                     : REQ_DAT_I[32*int'(grant_idx) +: 32];
                    sel_d    = REQ_SEL_I[4*int'(grant_idx) +: 4];
                    mgr_rd_d = REQ_READ_I[grant_idx];
                    mgr_wr_d = ~REQ_READ_I[grant_idx];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE:      state_d = S_WAIT_START;
            S_WAIT_START: if (MGR_BUSY_I) state_d = S_WAIT_END;
            S_WAIT_END: begin
                if (!MGR_BUSY_I) begin
                    if (rd_q) rdat_d[win_q] = MGR_DAT_I;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = win_q;
                state_d = S_IDLE;
            end
            default:      state_d = S_IDLE;
        endcase
    end

    // last_grant resets to the top port so port 0 is searched first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            last_q   <= IW'(NUM_REQ - 1);
            win_q    <= '0;
            rd_q     <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            rdat_q   <= '0;
            mgr_rd_q <= 1'b0;
            mgr_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            rd_q     <= rd_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            rdat_q   <= rdat_d;
            mgr_rd_q <= mgr_rd_d;
            mgr_wr_q <= mgr_wr_d;
        end
    end

    assign active      = (state_q != S_IDLE);
    assign MGR_READ_O  = mgr_rd_q;
    assign MGR_WRITE_O = mgr_wr_q;
    assign MGR_ADR_O   = active ? adr_q  : 32'h0;
    assign MGR_DAT_O   = active ? wdat_q : 32'h0;
    assign MGR_SEL_O   = active ? sel_q  : 4'h0;
    assign REQ_DAT_O   = rdat_q;

    always_comb begin
        REQ_BUSY_O = '0;
        REQ_DONE_O = '0;
        if (active)             REQ_BUSY_O[win_q] = 1'b1;
        if (state_q == S_DONE)  REQ_DONE_O[win_q] = 1'b1;
    end

endmodule

// File: tb/tb_wb_requester_arbiter.sv
// Directed bench for wb_requester_arbiter with a simple latency-programmable
// bus manager stub.
module tb_wb_requester_arbiter;

    localparam int N = 2;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic [N-1:0]    REQ_READ_I = '0;
    logic [N-1:0]    REQ_WRITE_I = '0;
    logic [N*32-1:0] REQ_ADR_I = '0;
    logic [N*32-1:0] REQ_DAT_I = '0;
    logic [N*4-1:0]  REQ_SEL_I = '0;
    logic [N*32-1:0] REQ_DAT_O;
    logic [N-1:0]    REQ_BUSY_O;
    logic [N-1:0]    REQ_DONE_O;
    logic            MGR_READ_O, MGR_WRITE_O;
    logic [31:0]     MGR_ADR_O, MGR_DAT_O;
    logic [3:0]      MGR_SEL_O;
    logic            MGR_BUSY_I;
    logic [31:0]     MGR_DAT_I;

    int vectors = 0;
    int miscompares = 0;

    // manager stub controls / observations
    int          mgr_lat = 0;
    logic [31:0] mgr_rdata = '0;
    int          mgr_cnt;
    int          strobe_cnt;
    logic        overlap;

    wb_requester_arbiter #(.NUM_REQ(N)) dut (
        .CLK(CLK), .nRST(nRST),
        .REQ_READ_I(REQ_READ_I), .REQ_WRITE_I(REQ_WRITE_I),
        .REQ_ADR_I(REQ_ADR_I), .REQ_DAT_I(REQ_DAT_I), .REQ_SEL_I(REQ_SEL_I),
        .REQ_DAT_O(REQ_DAT_O), .REQ_BUSY_O(REQ_BUSY_O), .REQ_DONE_O(REQ_DONE_O),
        .MGR_READ_O(MGR_READ_O), .MGR_WRITE_O(MGR_WRITE_O),
        .MGR_ADR_O(MGR_ADR_O), .MGR_DAT_O(MGR_DAT_O), .MGR_SEL_O(MGR_SEL_O),
        .MGR_BUSY_I(MGR_BUSY_I), .MGR_DAT_I(MGR_DAT_I)
    );

    always #5 CLK = ~CLK;

    // Busy rises the edge after a strobe, stays up mgr_lat+1 cycles, and
    // read data appears as busy falls.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            MGR_BUSY_I <= 1'b0;
            MGR_DAT_I  <= '0;
            mgr_cnt    <= 0;
            strobe_cnt <= 0;
            overlap    <= 1'b0;
        end else if (MGR_READ_O || MGR_WRITE_O) begin
            if (MGR_BUSY_I) overlap <= 1'b1;
            MGR_BUSY_I <= 1'b1;
            mgr_cnt    <= mgr_lat;
            strobe_cnt <= strobe_cnt + 1;
        end else if (MGR_BUSY_I) begin
            if (mgr_cnt == 0) begin
                MGR_BUSY_I <= 1'b0;
                MGR_DAT_I  <= mgr_rdata;
            end else begin
                mgr_cnt <= mgr_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        REQ_READ_I = '0;
        REQ_WRITE_I = '0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        REQ_READ_I[p]        = rd;
        REQ_WRITE_I[p]       = wr;
        REQ_ADR_I[p*32 +: 32] = adr;
        REQ_DAT_I[p*32 +: 32] = dat;
        REQ_SEL_I[p*4 +: 4]   = sel;
    endtask

    task automatic wait_strobe(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (MGR_READ_O || MGR_WRITE_O) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_strobe_seen"}, {31'h0, ok}, 32'h1);
    endtask

    // Optionally checks the in-flight indication every cycle until DONE.
    task automatic wait_done(input string tag, input int p, input bit chk_busy);
        bit ok = 1'b0;
        logic [N-1:0] exp_busy;
        exp_busy = '0;
        exp_busy[p] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (chk_busy) begin
                chk({tag, "_busy_held"}, {30'h0, REQ_BUSY_O}, {30'h0, exp_busy});
                chk({tag, "_no_restrobe"}, {31'h0, MGR_READ_O | MGR_WRITE_O}, 32'h0);
            end
            if (REQ_DONE_O[p]) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic drop_after_done(input int p);
        @(posedge CLK);
        #1;
        REQ_READ_I[p]  = 1'b0;
        REQ_WRITE_I[p] = 1'b0;
    endtask

    int s0;

    initial begin
        // ---- reset state ----
        @(negedge CLK);
        chk("rst_mgr_rd", {31'h0, MGR_READ_O}, 32'h0);
        chk("rst_mgr_wr", {31'h0, MGR_WRITE_O}, 32'h0);
        chk("rst_mgr_adr", MGR_ADR_O, 32'h0);
        chk("rst_busy", {30'h0, REQ_BUSY_O}, 32'h0);
        chk("rst_dat0", REQ_DAT_O[31:0], 32'h0);
        do_reset();

        // ---- single read on port 0 ----
        mgr_lat = 0;
        mgr_rdata = 32'hDEAD_BEEF;
        set_req(0, 1, 0, 32'h3000_0010, 32'h5555_5555, 4'hF);
        s0 = strobe_cnt;
        wait_strobe("rd1");
        chk("rd1_read", {31'h0, MGR_READ_O}, 32'h1);
        chk("rd1_write", {31'h0, MGR_WRITE_O}, 32'h0);
        chk("rd1_adr", MGR_ADR_O, 32'h3000_0010);
        chk("rd1_dat_zero", MGR_DAT_O, 32'h0);
        chk("rd1_sel", {28'h0, MGR_SEL_O}, 32'hF);
        chk("rd1_busy", {30'h0, REQ_BUSY_O}, 32'h1);
        @(negedge CLK);
        chk("rd1_strobe_1cyc", {31'h0, MGR_READ_O}, 32'h0);
        wait_done("rd1", 0, 1'b0);
        chk("rd1_rdat", REQ_DAT_O[31:0], 32'hDEAD_BEEF);
        chk("rd1_done_vec", {30'h0, REQ_DONE_O}, 32'h1);
        drop_after_done(0);
        @(negedge CLK);
        chk("rd1_done_pulse", {30'h0, REQ_DONE_O}, 32'h0);
        chk("rd1_idle_busy", {30'h0, REQ_BUSY_O}, 32'h0);
        chk("rd1_idle_adr", MGR_ADR_O, 32'h0);
        chk("rd1_one_txn", strobe_cnt - s0, 32'd1);

        // ---- contention: both write from reset ----
        do_reset();
        set_req(0, 0, 1, 32'h0000_0100, 32'h1111_1111, 4'hF);
        set_req(1, 0, 1, 32'h0000_0200, 32'h2222_2222, 4'h3);
        wait_strobe("ct0");
        chk("ct0_write", {31'h0, MGR_WRITE_O}, 32'h1);
        chk("ct0_dat", MGR_DAT_O, 32'h1111_1111);
        chk("ct0_busy", {30'h0, REQ_BUSY_O}, 32'h1);
        wait_done("ct0", 0, 1'b0);
        chk("ct0_rdat_kept", REQ_DAT_O[31:0], 32'h0);
        drop_after_done(0);
        wait_strobe("ct1");
        chk("ct1_dat", MGR_DAT_O, 32'h2222_2222);
        chk("ct1_adr", MGR_ADR_O, 32'h0000_0200);
        chk("ct1_sel", {28'h0, MGR_SEL_O}, 32'h3);
        chk("ct1_busy", {30'h0, REQ_BUSY_O}, 32'h2);
        wait_done("ct1", 1, 1'b0);
        drop_after_done(1);

        // ---- fairness: continuous reads on both ports ----
        do_reset();
        mgr_lat = 1;
        set_req(0, 1, 0, 32'h0000_1000, 32'h0, 4'hF);
        set_req(1, 1, 0, 32'h0000_2000, 32'h0, 4'hF);
        for (int t = 0; t < 6; t++) begin
            mgr_rdata = 32'hA0 + t;
            wait_strobe("fair");
            chk("fair_grant", {30'h0, REQ_BUSY_O}, (t % 2 == 0) ? 32'h1 : 32'h2);
            wait_done("fair", t % 2, 1'b0);
            chk("fair_rdat", REQ_DAT_O[(t % 2)*32 +: 32], 32'hA0 + t);
        end
        REQ_READ_I = '0;
        @(negedge CLK);

        // ---- illegal request on port 1, port 0 idle ----
        do_reset();
        s0 = strobe_cnt;
        set_req(1, 1, 1, 32'h0000_3000, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("ill_no_strobe", {31'h0, MGR_READ_O | MGR_WRITE_O}, 32'h0);
            chk("ill_busy", {30'h0, REQ_BUSY_O}, 32'h0);
        end
        chk("ill_txn_count", strobe_cnt - s0, 32'd0);
        REQ_READ_I = '0;
        REQ_WRITE_I = '0;

        // ---- delayed ack, 10 cycles ----
        mgr_lat = 10;
        s0 = strobe_cnt;
        set_req(0, 0, 1, 32'h0000_4000, 32'hCAFE_F00D, 4'h5);
        wait_strobe("dly");
        chk("dly_write", {31'h0, MGR_WRITE_O}, 32'h1);
        wait_done("dly", 0, 1'b1);
        chk("dly_one_txn", strobe_cnt - s0, 32'd1);
        chk("dly_no_overlap", {31'h0, overlap}, 32'h0);
        drop_after_done(0);

        // ---- reset in WAIT_END, then port 0 must win ----
        mgr_rdata = 32'h1234_5678;
        set_req(1, 1, 0, 32'h0000_5000, 32'h0, 4'hF);
        wait_strobe("rwe");
        repeat (4) @(negedge CLK);
        chk("rwe_in_flight", {30'h0, REQ_BUSY_O}, 32'h2);
        set_req(0, 1, 0, 32'h0000_6000, 32'h0, 4'hF);
        nRST = 1'b0;
        #1;
        chk("rwe_busy0", {30'h0, REQ_BUSY_O}, 32'h0);
        chk("rwe_done0", {30'h0, REQ_DONE_O}, 32'h0);
        chk("rwe_adr0", MGR_ADR_O, 32'h0);
        chk("rwe_rdat1", REQ_DAT_O[63:32], 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        wait_strobe("rwe_next");
        chk("rwe_grant0", {30'h0, REQ_BUSY_O}, 32'h1);
        chk("rwe_adr", MGR_ADR_O, 32'h0000_6000);
        wait_done("rwe_next", 0, 1'b0);
        chk("rwe_rdat", REQ_DAT_O[31:0], 32'h1234_5678);
        REQ_READ_I = '0;
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_requester_arbiter.md
WB_REQUESTER_ARBITER -- requirements
Module: wb_requester_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of requester ports (legal range 2..4).
REQ-002 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port REQ_READ_I  input  NUM_REQ  per-requester read request (level).
REQ-005 SHALL have port REQ_WRITE_I  input  NUM_REQ  per-requester write request (level).
REQ-006 SHALL have port REQ_ADR_I  input  NUM_REQx32  per-requester address.
REQ-007 SHALL have port REQ_DAT_I  input  NUM_REQx32  per-requester write data.
REQ-008 SHALL have port REQ_SEL_I  input  NUM_REQx4  per-requester byte select.
REQ-009 SHALL have port REQ_DAT_O  output  NUM_REQx32  per-requester read data, valid with REQ_DONE_O.
REQ-010 SHALL have port REQ_BUSY_O  output  NUM_REQ  requester's transaction is in flight.
REQ-011 SHALL have port REQ_DONE_O  output  NUM_REQ  one-cycle completion pulse.
REQ-012 SHALL have ports MGR_READ_O and MGR_WRITE_O  output  1 each  request strobes to the bus manager.
REQ-013 SHALL have ports MGR_ADR_O (32), MGR_DAT_O (32) and MGR_SEL_O (4)  output  transaction fields to the manager.
REQ-014 SHALL have ports MGR_BUSY_I (1) and MGR_DAT_I (32)  input  manager busy flag and manager read data.

Function
REQ-015 SHALL treat requester i as eligible when exactly one of REQ_READ_I[i] and REQ_WRITE_I[i] is high; a port asserting both SHALL be ignored.
REQ-016 SHALL implement the FSM IDLE -> ISSUE -> WAIT_START -> WAIT_END -> DONE -> IDLE.
REQ-017 IDLE: when any port is eligible, SHALL pick the winner round-robin, starting the search at index (last_grant+1) mod NUM_REQ.
REQ-018 IDLE: SHALL register the winner's index, op, ADR, DAT and SEL, then go to ISSUE.
REQ-019 ISSUE: SHALL assert exactly one of MGR_READ_O or MGR_WRITE_O for exactly one cycle, then go to WAIT_START.
REQ-020 MGR_READ_O and MGR_WRITE_O SHALL be registered and low in every state except ISSUE.
REQ-021 MGR_ADR_O, MGR_DAT_O and MGR_SEL_O SHALL hold the captured values from ISSUE through DONE, and be 0 otherwise.
REQ-022 MGR_DAT_O SHALL be 0 for a read.
REQ-023 WAIT_START: SHALL wait for MGR_BUSY_I=1, then go to WAIT_END; there is no timeout.
REQ-024 WAIT_END: on the first cycle MGR_BUSY_I=0, SHALL capture MGR_DAT_I into REQ_DAT_O[winner] for a read (a write leaves it unchanged), then go to DONE.
REQ-025 DONE: SHALL pulse REQ_DONE_O[winner] for 1 cycle, set last_grant=winner, then go to IDLE.
REQ-026 REQ_BUSY_O[winner] SHALL be high from ISSUE through DONE inclusive; all other ports SHALL read 0.
REQ-027 REQ_DAT_O[i] SHALL hold its last captured value until that port's next read completes.
REQ-028 Requesters SHALL hold their request stable until DONE and deassert it on the edge ending DONE.
REQ-029 Requests are not sampled outside IDLE, so a request withdrawn mid-transaction SHALL NOT abort it.
REQ-030 Minimum turnaround SHALL be 5 cycles plus the manager latency; no back-to-back overlap is permitted.
REQ-031 Only one transaction SHALL be outstanding at a time.

Reset
REQ-032 On nRST=0, SHALL enter IDLE asynchronously with last_grant=NUM_REQ-1, so that port 0 wins first.
REQ-033 On nRST=0, all outputs and all captured registers SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no DONE pulse; the manager is reset by the same nRST.

Structure
REQ-035 A shared package wb_arb_pkg SHALL hold the FSM state enum and the NUM_REQ default.
REQ-036 Round-robin selection SHALL be a combinational sub-module rr_priority_picker, with inputs eligible[NUM_REQ] and last_grant, and outputs grant_valid and grant_idx.

Verification
REQ-037 Single read: port0 read ADR=0x3000_0010, manager returns 0xDEAD_BEEF -> MGR_READ_O one cycle; REQ_DONE_O[0] one pulse; REQ_DAT_O[0]=0xDEAD_BEEF.
REQ-038 Contention: ports 0 and 1 both write from reset -> port0 served first, then port1; MGR_DAT_O equals each port's data in turn.
REQ-039 Fairness: both ports request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-040 Illegal request: port1 asserts read and write together while port0 is idle -> no MGR strobe and REQ_BUSY_O=0.
REQ-041 Delayed ACK of 10 cycles: strobe stays a single cycle, REQ_BUSY_O[0] stays high throughout, and the manager issues no duplicate transaction.
REQ-042 Reset asserted in WAIT_END -> all outputs 0 immediately; the next request is granted to port0.
